// File: rtl/tf_buf_pkg.sv
// Shared types and constants for the ping-pong twiddle-factor buffer.
// Build option TF_BUF_PARITY_EN stores one even-parity bit per bank word.
package tf_buf_pkg;

   typedef enum logic [1:0] {
      SH_EMPTY   = 2'd0,
      SH_FILLING = 2'd1,
      SH_FULL    = 2'd2
   } shadow_state_t;

`ifdef TF_BUF_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/tf_bank_2p.sv
// One twiddle bank: simple dual-port RAM holding both halves, plus RD_LAT read pipeline.
// With TF_BUF_PARITY_EN each word carries an even-parity bit checked on the way out.
module tf_bank_2p
   import tf_buf_pkg::*;
#(
   parameter int DEPTH      = 4096,
   parameter int DATA_WIDTH = 216,
   parameter int RD_LAT     = 2,
   localparam int AW        = addr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW:0]           wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [RD_LAT-1:0]     stage_en,
   input  logic [AW:0]           rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_perr
);

   localparam int WW = DATA_WIDTH + PAR_W;

   logic [WW-1:0] mem [2*DEPTH];
   logic [WW-1:0] pipe [RD_LAT];
   logic [WW-1:0] wr_word;

`ifdef TF_BUF_PARITY_EN
   assign wr_word = {^wr_data, wr_data};
   assign rd_perr = ^pipe[RD_LAT-1];
`else
   assign wr_word = wr_data;
   assign rd_perr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_word;
   end

   // Each stage only advances behind a valid read, so the last stage holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < RD_LAT; j++) pipe[j] <= '0;
      end else begin
         if (stage_en[0]) pipe[0] <= mem[rd_addr];
         for (int j = 1; j < RD_LAT; j++) begin
            if (stage_en[j]) pipe[j] <= pipe[j-1];
         end
      end
   end

   assign rd_data = pipe[RD_LAT-1][DATA_WIDTH-1:0];

endmodule

// File: rtl/tf_buffer_pp.sv
// Ping-pong twiddle buffer: loader fills the shadow half while compute reads the active half.
// TF_BUF_PARITY_EN (optional) enables per-bank parity storage and rd_perr reporting.
//
// state      | meaning
// SH_EMPTY   | shadow half holds no rows of the next set
// SH_FILLING | shadow half partially loaded
// SH_FULL    | shadow half complete, loader stalled until swap
module tf_buffer_pp
   import tf_buf_pkg::*;
#(
   parameter int NUM_BANKS  = 128,
   parameter int DATA_WIDTH = 216,
   parameter int DEPTH      = 4096,
   parameter int RD_LAT     = 2,
   localparam int AW        = addr_w(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            ld_valid,
   output logic                            ld_ready,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] ld_data,
   input  logic                            ld_last,
   output logic [AW:0]                     ld_rows,
   output logic                            ld_ovf,
   output logic                            shadow_full,
   input  logic                            swap_req,
   output logic                            swap_ack,
   output logic                            active_sel,
   input  logic                            rd_en,
   input  logic [NUM_BANKS*AW-1:0]         rd_addr,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
   output logic                            rd_valid,
   output logic [NUM_BANKS-1:0]            rd_perr
);

   localparam logic [AW:0] LAST_ROW = (AW+1)'(DEPTH - 1);

   shadow_state_t        state;
   logic [AW-1:0]        wr_ptr;
   logic                 accept;
   logic [RD_LAT-1:0]    vld;
   logic [RD_LAT-1:0]    stage_en;
   logic [NUM_BANKS-1:0] bank_perr;

   assign accept = ld_valid && ld_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SH_EMPTY;
         wr_ptr      <= '0;
         ld_rows     <= '0;
         ld_ovf      <= 1'b0;
         ld_ready    <= 1'b1;
         shadow_full <= 1'b0;
         swap_ack    <= 1'b0;
         active_sel  <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         case (state)
            SH_EMPTY, SH_FILLING: begin
               if (accept) begin
                  wr_ptr  <= wr_ptr + 1'b1;
                  ld_rows <= ld_rows + 1'b1;
                  if (ld_last || ld_rows == LAST_ROW) begin
                     state       <= SH_FULL;
                     ld_ready    <= 1'b0;
                     shadow_full <= 1'b1;
                     if (!ld_last) ld_ovf <= 1'b1;
                  end else begin
                     state <= SH_FILLING;
                  end
               end
            end
            SH_FULL: begin
               if (swap_req) begin
                  state       <= SH_EMPTY;
                  active_sel  <= ~active_sel;
                  swap_ack    <= 1'b1;
                  wr_ptr      <= '0;
                  ld_rows     <= '0;
                  ld_ready    <= 1'b1;
                  shadow_full <= 1'b0;
               end
            end
            default: begin
               state       <= SH_EMPTY;
               ld_ready    <= 1'b1;
               shadow_full <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
      end else begin
         vld[0] <= rd_en;
         for (int j = 1; j < RD_LAT; j++) vld[j] <= vld[j-1];
      end
   end

   always_comb begin
      stage_en    = '0;
      stage_en[0] = rd_en;
      for (int j = 1; j < RD_LAT; j++) stage_en[j] = vld[j-1];
   end

   assign rd_valid = vld[RD_LAT-1];
   assign rd_perr  = bank_perr & {NUM_BANKS{rd_valid}};

   // The half bit rides with the address into the RAM at issue, so in-flight reads survive a swap.
   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      tf_bank_2p #(
         .DEPTH      (DEPTH),
         .DATA_WIDTH (DATA_WIDTH),
         .RD_LAT     (RD_LAT)
      ) u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (accept),
         .wr_addr  ({~active_sel, wr_ptr}),
         .wr_data  (ld_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .stage_en (stage_en),
         .rd_addr  ({active_sel, rd_addr[i*AW +: AW]}),
         .rd_data  (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .rd_perr  (bank_perr[i])
      );
   end

endmodule

// File: doc/tf_buffer_pp.md
Name: tf_buffer_pp

Overview:
- Ping-pong twiddle-factor buffer, successor to the single-bank-set TF store; NUM_BANKS independent banks, each split into two halves (active/shadow).
- Compute datapath reads per-bank addresses from the active half; DMA loader streams the next limb set's twiddles, one full row per beat, into the shadow half in parallel.
- A swap handshake exchanges halves between limb sets, hiding twiddle reload latency behind NTT/DFT compute.

Parameters:
NUM_BANKS, 128, number of banks (dp/2 butterflies)
DATA_WIDTH, 216, bits per bank word (3 x 72-bit twiddles)
DEPTH, 4096, words per half per bank; power of two, >=2
RD_LAT, 2, read latency in cycles from rd_en to rd_valid; >=1
AW, $clog2(DEPTH), derived localparam, per-bank address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader beat valid
ld_ready  out  1  buffer accepts beat
ld_data  in  NUM_BANKS*DATA_WIDTH  one row; bank i at [i*DATA_WIDTH +: DATA_WIDTH]
ld_last  in  1  final row of the set
ld_rows  out  AW+1  rows written into shadow half
ld_ovf  out  1  sticky: DEPTH rows written without ld_last
shadow_full  out  1  shadow half complete, awaiting swap
swap_req  in  1  level request to swap halves
swap_ack  out  1  one-cycle pulse when swap takes effect
active_sel  out  1  which half is active
rd_en  in  1  read issue
rd_addr  in  NUM_BANKS*AW  per-bank read address
rd_data  out  NUM_BANKS*DATA_WIDTH  read data
rd_valid  out  1  rd_data valid
rd_perr  out  NUM_BANKS  per-bank parity error, qualified by rd_valid

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous active-low, rst_n.
- Reset values: active_sel=0, state EMPTY, ld_rows=0, ld_ovf=0, shadow_full=0, swap_ack=0, rd_valid=0, rd_data=0, rd_perr=0; ld_ready=1 as soon as rst_n deasserts. RAM contents not reset (active half undefined after reset).
- Shadow FSM states:
  - EMPTY: ld_ready=1.
  - FILLING: ld_ready=1.
  - FULL: ld_ready=0, shadow_full=1.
- Load transitions:
  - A beat is accepted when ld_valid&&ld_ready. It writes every bank at {~active_sel, wr_ptr}, then wr_ptr and ld_rows increment.
  - EMPTY/FILLING -> FILLING on an accepted beat without ld_last.
  - -> FULL on an accepted beat with ld_last.
  - -> FULL when the DEPTH-th beat is accepted without ld_last; that beat also sets ld_ovf (sticky until reset).
- Swap:
  - In FULL with swap_req=1: active_sel toggles and swap_ack pulses, both on the next edge. State -> EMPTY, wr_ptr=0, ld_rows=0.
  - swap_req outside FULL is held off (no ack). Earliest ack is the cycle after FULL is entered, so ld_last and swap_req in the same cycle ack one cycle later.
  - swap_req must drop after swap_ack; if still high it is ignored until the next FULL.
- Read:
  - Fully pipelined, one issue per cycle. The half bit is captured at issue, so reads issued before the swap edge return old-half data even if rd_valid arrives after the swap.
  - rd_valid asserts exactly RD_LAT cycles after rd_en. rd_data holds its value when rd_valid=0.
- Ports never collide: writes target the shadow half and reads the active half, so no read-during-write hazard exists.
- Reset mid-load or mid-read: pipeline is flushed (rd_valid=0), any partial load is discarded, active_sel returns to 0.

Optional Feature:
- TF_BUF_PARITY_EN defined:
  - Each bank word stores one extra even-parity bit, computed on write.
  - Parity is recomputed on read; rd_perr[i]=1 with rd_valid if bank i mismatches.
- Undefined: no parity storage; rd_perr tied to 0 (port always present).

Decomposition:
- Package tf_buf_pkg: shadow state enum (EMPTY/FILLING/FULL), parity-width constant (PAR_W = 1 or 0 from macro), addr-width helper function.
- Sub-module tf_bank_2p: simple dual-port RAM of 2*DEPTH x (DATA_WIDTH+PAR_W) with write port, read port and RD_LAT output pipeline, URAM-inferable; instantiated NUM_BANKS times in a generate loop.
- Top holds the FSM, counters, swap logic and valid pipeline.

Test Plan:
(Bench config NUM_BANKS=4, DATA_WIDTH=16, DEPTH=8, RD_LAT=2.)
- Reset released -> ld_ready=1, active_sel=0, shadow_full=0, rd_valid=0, ld_rows=0.
- 3 beats (rows 0x0A0A.., 0x0B0B.., 0x0C0C..) with ld_valid gaps, ld_last on 3rd -> ld_rows=3, shadow_full=1, ld_ready=0. Then swap_req -> swap_ack next cycle, active_sel=1. Read rd_addr={2,1,0,2} -> rd_valid 2 cycles later with bank words {0x0C0C,0x0B0B,0x0A0A,0x0C0C}.
- 8 beats, no ld_last -> FULL after 8th, ld_ovf=1, 9th ld_valid not accepted (ld_ready=0).
- Read issued the cycle before swap_ack -> returns old-half data; read issued the cycle after -> new-half data.
- swap_req held high from EMPTY through a 2-beat load -> swap_ack exactly one cycle after shadow_full rises, single pulse.
- With TF_BUF_PARITY_EN, backdoor flip of a bit in bank 1 word 0 -> read addr 0 gives rd_perr=4'b0010 with rd_valid. Without the macro, rd_perr=0.
